updi_prog_sequencer: RTL and testbench

Parametrised UPDI programming sequencer; it generalises the programmer state machine into an operation-selectable engine with timeouts and retries. It accepts one operation per start: read device ID, chip-erase unlock, enter NVMPROG, or leave programming. It emits UPDI instruction bytes to the UART/UPDI byte link and consumes its responses. The byte link strips half-duplex echo before bytes reach rx.

---
 rtl/updi_prog_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_updi_prog_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_prog_sequencer.sv
// UPDI programming sequencer: read device ID, chip-erase unlock, enter NVMPROG or leave programming,
// with per-step timeouts and full-sequence retries. Define UPDI_PROG_SIG_CHECK_EN to verify the signature.
module updi_prog_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned POLL_LIMIT     = 255,
    parameter logic [15:0] SIG_ADDR       = 16'h1100,
    parameter logic [23:0] EXPECTED_ID    = 24'h1E9422
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [23:0] dev_id,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        brk_req,
    input  logic        brk_done
);
    typedef enum logic [2:0] {ST_IDLE, ST_BREAK, ST_BRK_WAIT, ST_TX, ST_RX, ST_DONE, ST_ERROR} state_t;
    typedef enum logic [3:0] {STEP_CTRLB, STEP_CTRLA, STEP_STATUSA, STEP_KEY, STEP_KEYST,
                              STEP_RSTA, STEP_RSTR, STEP_UPDIDIS, STEP_POLL, STEP_SIG} step_t;

    localparam logic [63:0] KEY_ERASE = 64'h4E564D4572617365;
    localparam logic [63:0] KEY_PROG  = 64'h4E564D50726F6720;

    state_t      state, state_n;
    step_t       step, step_n;
    logic [3:0]  idx, idx_n, last_idx;
    logic [1:0]  sig_idx, sig_idx_n, op_q, op_q_n;
    logic [15:0] sig_buf, sig_buf_n, sig_addr;
    logic [31:0] retries, retries_n, poll_cnt, poll_cnt_n, timer, timer_n;
    logic [2:0]  err_code_n;
    logic [23:0] dev_id_n;
    logic        key_fail, key_fail_n, rx_step, timeout, timer_hit;
    logic [7:0]  tx_byte;
    logic [63:0] key_vec;
    logic [2:0]  key_idx;

`ifndef UPDI_PROG_SIG_CHECK_EN
    logic unused_expected_id;
    assign unused_expected_id = ^EXPECTED_ID;
`endif

    assign key_vec   = (op_q == 2'd1) ? KEY_ERASE : KEY_PROG;
    assign key_idx   = 3'(idx - 4'd2);
    assign sig_addr  = SIG_ADDR + {14'd0, sig_idx};
    assign timer_hit = (timer >= TIMEOUT_CYCLES - 32'd1);

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERROR);
    assign tx_valid = (state == ST_TX);
    assign brk_req  = (state == ST_BREAK);
    assign tx_data  = tx_valid ? tx_byte : 8'h00;

    // Every UPDI frame opens with SYNC (0x55); the step selects the remaining bytes.
    always_comb begin
        tx_byte  = 8'h55;
        last_idx = 4'd2;
        rx_step  = 1'b0;
        case (step)
            STEP_CTRLB:   if (idx == 4'd1) tx_byte = 8'hC3; else if (idx == 4'd2) tx_byte = 8'h08;
            STEP_CTRLA:   if (idx == 4'd1) tx_byte = 8'hC2; else if (idx == 4'd2) tx_byte = 8'h06;
            STEP_STATUSA: begin
                last_idx = 4'd1;
                rx_step  = 1'b1;
                if (idx == 4'd1) tx_byte = 8'h80;
            end
            STEP_KEY: begin
                last_idx = 4'd9;
                if (idx == 4'd1) tx_byte = 8'hE0;
                else if (idx >= 4'd2) tx_byte = key_vec[{key_idx, 3'b000} +: 8];
            end
            STEP_KEYST: begin
                last_idx = 4'd1;
                rx_step  = 1'b1;
                if (idx == 4'd1) tx_byte = 8'h87;
            end
            STEP_RSTA:    if (idx == 4'd1) tx_byte = 8'hC8; else if (idx == 4'd2) tx_byte = 8'h59;
            STEP_RSTR:    if (idx == 4'd1) tx_byte = 8'hC8; else if (idx == 4'd2) tx_byte = 8'h00;
            STEP_UPDIDIS: if (idx == 4'd1) tx_byte = 8'hC3; else if (idx == 4'd2) tx_byte = 8'h0C;
            STEP_POLL: begin
                last_idx = 4'd1;
                rx_step  = 1'b1;
                if (idx == 4'd1) tx_byte = 8'h8B;
            end
            STEP_SIG: begin
                last_idx = 4'd3;
                rx_step  = 1'b1;
                if (idx == 4'd1) tx_byte = 8'h04;
                else if (idx == 4'd2) tx_byte = sig_addr[7:0];
                else if (idx == 4'd3) tx_byte = sig_addr[15:8];
            end
            default: ;
        endcase
    end

    // Sequencing: the timer runs in every waiting state and is reloaded by any link progress.
    always_comb begin
        state_n    = state;
        step_n     = step;
        idx_n      = idx;
        sig_idx_n  = sig_idx;
        sig_buf_n  = sig_buf;
        retries_n  = retries;
        poll_cnt_n = poll_cnt;
        timer_n    = timer;
        err_code_n = err_code;
        dev_id_n   = dev_id;
        op_q_n     = op_q;
        key_fail_n = key_fail;
        timeout    = 1'b0;

        if (state == ST_BRK_WAIT || state == ST_TX || state == ST_RX)
            timer_n = timer + 32'd1;

        case (state)
            ST_IDLE: if (start) begin
                op_q_n     = op;
                retries_n  = '0;
                poll_cnt_n = '0;
                timer_n    = '0;
                err_code_n = 3'd0;
                key_fail_n = 1'b0;
                state_n    = ST_BREAK;
            end
            ST_BREAK: state_n = ST_BRK_WAIT;
            ST_BRK_WAIT: if (brk_done) begin
                timer_n = '0;
                step_n  = STEP_CTRLB;
                idx_n   = '0;
                state_n = ST_TX;
            end else timeout = timer_hit;
            ST_TX: if (tx_ready) begin
                timer_n = '0;
                if (idx != last_idx) idx_n = idx + 4'd1;
                else begin
                    idx_n = '0;
                    if (rx_step) state_n = ST_RX;
                    else begin
                        case (step)
                            STEP_CTRLB:   step_n = STEP_CTRLA;
                            STEP_CTRLA:   step_n = STEP_STATUSA;
                            STEP_KEY:     step_n = STEP_KEYST;
                            STEP_RSTA:    step_n = STEP_RSTR;
                            STEP_RSTR: begin
                                if (key_fail) begin
                                    err_code_n = 3'd3;
                                    state_n    = ST_ERROR;
                                end else if (op_q == 2'd3) step_n = STEP_UPDIDIS;
                                else begin
                                    step_n     = STEP_POLL;
                                    poll_cnt_n = '0;
                                end
                            end
                            STEP_UPDIDIS: state_n = ST_DONE;
                            default: ;
                        endcase
                    end
                end
            end else timeout = timer_hit;
            ST_RX: if (rx_valid) begin
                timer_n = '0;
                state_n = ST_TX;
                case (step)
                    STEP_STATUSA: begin
                        if (rx_data == 8'h00) begin
                            err_code_n = 3'd2;
                            state_n    = ST_ERROR;
                        end else if (op_q == 2'd0) begin
                            step_n    = STEP_SIG;
                            sig_idx_n = 2'd0;
                        end else if (op_q == 2'd3) step_n = STEP_RSTA;
                        else step_n = STEP_KEY;
                    end
                    STEP_KEYST: begin
                        if (!((op_q == 2'd1) ? rx_data[3] : rx_data[4])) key_fail_n = 1'b1;
                        step_n = STEP_RSTA;
                    end
                    STEP_POLL: begin
                        if ((op_q == 2'd1) ? !rx_data[0] : rx_data[3]) state_n = ST_DONE;
                        else if (poll_cnt + 32'd1 >= POLL_LIMIT) begin
                            err_code_n = 3'd4;
                            state_n    = ST_ERROR;
                        end else poll_cnt_n = poll_cnt + 32'd1;
                    end
                    STEP_SIG: begin
                        sig_buf_n = {sig_buf[7:0], rx_data};
                        if (sig_idx == 2'd2) begin
                            dev_id_n = {sig_buf, rx_data};
`ifdef UPDI_PROG_SIG_CHECK_EN
                            if ({sig_buf, rx_data} != EXPECTED_ID) begin
                                err_code_n = 3'd5;
                                state_n    = ST_ERROR;
                            end else state_n = ST_DONE;
`else
                            state_n = ST_DONE;
`endif
                        end else sig_idx_n = sig_idx + 2'd1;
                    end
                    default: ;
                endcase
            end else timeout = timer_hit;
            ST_DONE, ST_ERROR: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        if (timeout) begin
            timer_n = '0;
            if (retries < MAX_RETRIES) begin
                retries_n  = retries + 32'd1;
                key_fail_n = 1'b0;
                state_n    = ST_BREAK;
            end else begin
                err_code_n = 3'd1;
                state_n    = ST_ERROR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            step     <= STEP_CTRLB;
            idx      <= '0;
            sig_idx  <= '0;
            sig_buf  <= '0;
            retries  <= '0;
            poll_cnt <= '0;
            timer    <= '0;
            err_code <= '0;
            dev_id   <= '0;
            op_q     <= '0;
            key_fail <= 1'b0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            idx      <= idx_n;
            sig_idx  <= sig_idx_n;
            sig_buf  <= sig_buf_n;
            retries  <= retries_n;
            poll_cnt <= poll_cnt_n;
            timer    <= timer_n;
            err_code <= err_code_n;
            dev_id   <= dev_id_n;
            op_q     <= op_q_n;
            key_fail <= key_fail_n;
        end
    end
endmodule

// File: tb/tb_updi_prog_sequencer.sv
// Bench for updi_prog_sequencer: a link model replays an expected UPDI transcript built from the
// protocol rules, with random handshake delays, stray rx bytes and random response values.
module tb_updi_prog_sequencer;
    localparam int unsigned TO  = 40;
    localparam int unsigned MR  = 3;
    localparam int unsigned PL  = 5;
    localparam logic [15:0] SA  = 16'hFFFE;
    localparam logic [23:0] EID = 24'h1E9422;
    localparam int K_TX = 0, K_RX = 1, K_BRK = 2;

    logic        clk = 1'b0;
    logic        rst, start, tx_ready, rx_valid, brk_done;
    logic [1:0]  op;
    logic [7:0]  rx_data;
    logic        busy, done, error, tx_valid, brk_req;
    logic [2:0]  err_code;
    logic [23:0] dev_id;
    logic [7:0]  tx_data;

    int          total = 0, bad = 0;
    int          exp_kind[$];
    logic [7:0]  exp_byte[$];
    int          brk_count, tx_count;
    bit          silent = 0;
    bit          aborted;
    logic [23:0] model_id = '0;

    always #5 clk = ~clk;

    updi_prog_sequencer #(
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .POLL_LIMIT(PL), .SIG_ADDR(SA), .EXPECTED_ID(EID)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .dev_id(dev_id), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .brk_req(brk_req),
        .brk_done(brk_done)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        exp_kind.push_back(k);
        exp_byte.push_back(b);
    endtask

    task automatic push_stcs(input logic [7:0] ins, input logic [7:0] val);
        push(K_TX, 8'h55); push(K_TX, ins); push(K_TX, val);
    endtask

    task automatic push_ldcs(input logic [7:0] ins, input logic [7:0] resp);
        push(K_TX, 8'h55); push(K_TX, ins); push(K_RX, resp);
    endtask

    task automatic push_prologue(input logic [7:0] statusa);
        push(K_BRK, 8'h00);
        push_stcs(8'hC3, 8'h08);
        push_stcs(8'hC2, 8'h06);
        push_ldcs(8'h80, statusa);
    endtask

    task automatic push_key(input logic [1:0] o, input logic [7:0] keyst);
        string s;
        s = (o == 2'd1) ? "NVMErase" : "NVMProg ";
        push(K_TX, 8'h55); push(K_TX, 8'hE0);
        for (int i = 7; i >= 0; i--) push(K_TX, s[i]);
        push_ldcs(8'h87, keyst);
    endtask

    task automatic push_reset_pair();
        push_stcs(8'hC8, 8'h59);
        push_stcs(8'hC8, 8'h00);
    endtask

    task automatic push_sig(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0]  b[3];
        logic [15:0] a;
        b[0] = b0; b[1] = b1; b[2] = b2;
        for (int i = 0; i < 3; i++) begin
            a = SA + 16'(i);
            push(K_TX, 8'h55); push(K_TX, 8'h04); push(K_TX, a[7:0]); push(K_TX, a[15:8]);
            push(K_RX, b[i]);
        end
    endtask

    // Start one operation and act as the byte link until done/error, a budget expiry,
    // or (abort_at >= 0) the moment tx byte number abort_at is offered.
    task automatic apply_stimulus(input logic [1:0] o, input int abort_at, output bit ab);
        int n, rdy_wait, rx_wait, brk_wait;
        bit rx_pending, brk_pending, front_tx;
        ab = 0; brk_count = 0; tx_count = 0; n = 0;
        rx_pending = 0; brk_pending = 0; rx_wait = 0; brk_wait = 0;
        rdy_wait = $urandom_range(0, 2);
        @(negedge clk); start = 1'b1; op = o;
        @(negedge clk);
        check_output("busy_after_start", busy, 1);
        while (n < 3000) begin
            start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; brk_done = 1'b0;
            if (done || error) break;
            if (n == 7) begin start = 1'b1; op = ~o; end
            if (brk_req) begin
                brk_count++;
                check_output("brk_expected", (exp_kind.size() > 0) ? exp_kind[0] : -1, K_BRK);
                if (exp_kind.size() > 0 && exp_kind[0] == K_BRK) begin
                    void'(exp_kind.pop_front()); void'(exp_byte.pop_front());
                end
                brk_pending = 1; brk_wait = $urandom_range(1, 3);
            end else if (brk_pending) begin
                if (brk_wait <= 1) begin brk_done = 1'b1; brk_pending = 0; end
                else brk_wait--;
            end
            if (rx_pending) begin
                if (rx_wait <= 1) begin
                    rx_valid = 1'b1; rx_data = exp_byte[0];
                    void'(exp_kind.pop_front()); void'(exp_byte.pop_front());
                    rx_pending = 0;
                end else rx_wait--;
            end else if (!silent && !(exp_kind.size() > 0 && exp_kind[0] == K_RX)
                         && $urandom_range(0, 5) == 0) begin
                rx_valid = 1'b1; rx_data = 8'($urandom);
            end
            if (tx_valid) begin
                if (tx_count == abort_at) begin ab = 1; return; end
                if (rdy_wait == 0) begin
                    front_tx = (exp_kind.size() > 0 && exp_kind[0] == K_TX);
                    check_output($sformatf("tx_byte%0d", tx_count), {23'd0, 1'b1, tx_data},
                                 {23'd0, front_tx, front_tx ? exp_byte[0] : 8'h00});
                    if (front_tx) begin void'(exp_kind.pop_front()); void'(exp_byte.pop_front()); end
                    tx_ready = 1'b1; tx_count++;
                    rdy_wait = $urandom_range(0, 2);
                    if (!silent && exp_kind.size() > 0 && exp_kind[0] == K_RX) begin
                        rx_pending = 1; rx_wait = $urandom_range(1, 3);
                    end
                end else rdy_wait--;
            end
            n++;
            @(negedge clk);
        end
        check_output("op_completes", {31'd0, done | error}, 1);
    endtask

    task automatic check_end(input string tag, input bit want_done, input logic [2:0] want_code);
        check_output({tag, "_done"}, done, want_done);
        check_output({tag, "_error"}, error, !want_done);
        check_output({tag, "_code"}, err_code, want_code);
        check_output({tag, "_devid"}, dev_id, model_id);
        check_output({tag, "_drained"}, exp_kind.size(), 0);
        check_output({tag, "_busy"}, busy, 1);
        @(negedge clk);
        check_output({tag, "_after"}, {done, error, busy}, 0);
        check_output({tag, "_held"}, err_code, want_code);
        exp_kind.delete(); exp_byte.delete();
    endtask

    task automatic read_id(input string tag, input logic [7:0] statusa,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        push_prologue(statusa);
        push_sig(b0, b1, b2);
        apply_stimulus(2'd0, -1, aborted);
        model_id = {b0, b1, b2};
`ifdef UPDI_PROG_SIG_CHECK_EN
        if ({b0, b1, b2} != EID) check_end(tag, 0, 3'd5);
        else check_end(tag, 1, 3'd0);
`else
        check_end(tag, 1, 3'd0);
`endif
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'd0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; brk_done = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_flags", {busy, done, error, tx_valid, brk_req}, 0);
        check_output("reset_code", err_code, 0);
        check_output("reset_devid", dev_id, 0);
        check_output("reset_txdata", tx_data, 0);
        rst = 1'b1;
        @(negedge clk);

        read_id("read_id", 8'h30, 8'h1E, 8'h94, 8'h22);

        push_prologue(8'h30);
        push_key(2'd2, 8'h10);
        push_reset_pair();
        push_ldcs(8'h8B, 8'h00);
        push_ldcs(8'h8B, 8'h00);
        push_ldcs(8'h8B, 8'h08);
        apply_stimulus(2'd2, -1, aborted);
        check_end("nvmprog", 1, 3'd0);

        silent = 1;
        repeat (MR + 1) begin
            push(K_BRK, 8'h00);
            push_stcs(8'hC3, 8'h08);
            push_stcs(8'hC2, 8'h06);
            push(K_TX, 8'h55); push(K_TX, 8'h80);
        end
        apply_stimulus(2'd1, -1, aborted);
        silent = 0;
        check_output("timeout_brks", brk_count, MR + 1);
        check_end("timeout", 0, 3'd1);

        push_prologue(8'h30);
        push_key(2'd1, 8'h00);
        push_reset_pair();
        apply_stimulus(2'd1, -1, aborted);
        check_end("key_reject", 0, 3'd3);

        push_prologue(8'h30);
        push_key(2'd2, 8'h10);
        apply_stimulus(2'd2, 13, aborted);
        check_output("abort_reached", aborted, 1);
        check_output("abort_key_byte", {tx_valid, tx_data}, {1'b1, 8'h72});
        #2 rst = 1'b0;
        #1;
        check_output("abort_async", {tx_valid, busy, brk_req}, 0);
        check_output("abort_devid", dev_id, 0);
        model_id = '0;
        exp_kind.delete(); exp_byte.delete();
        repeat (3) begin
            @(negedge clk);
            check_output("quiet_in_reset", {tx_valid, brk_req}, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_output("quiet_after_reset", {tx_valid, brk_req, busy}, 0);
        read_id("restart", 8'h30, 8'h1E, 8'h94, 8'h22);

        read_id("sig_other", 8'h30, 8'h1E, 8'h93, 8'h0B);

        push_prologue(8'($urandom_range(1, 255)));
        push_key(2'd1, 8'($urandom) | 8'h08);
        push_reset_pair();
        repeat (PL) push_ldcs(8'h8B, 8'($urandom) | 8'h01);
        apply_stimulus(2'd1, -1, aborted);
        check_end("poll_limit", 0, 3'd4);

        push_prologue(8'h00);
        apply_stimulus(2'($urandom_range(0, 3)), -1, aborted);
        check_end("statusa_zero", 0, 3'd2);

        push_prologue(8'($urandom_range(1, 255)));
        push_reset_pair();
        push_stcs(8'hC3, 8'h0C);
        apply_stimulus(2'd3, -1, aborted);
        check_end("leave", 1, 3'd0);

        push_prologue(8'($urandom_range(1, 255)));
        push_key(2'd1, 8'($urandom) | 8'h08);
        push_reset_pair();
        push_ldcs(8'h8B, 8'($urandom) | 8'h01);
        push_ldcs(8'h8B, 8'($urandom) & 8'hFE);
        apply_stimulus(2'd1, -1, aborted);
        check_end("erase_ok", 1, 3'd0);

        for (int k = 0; k < 3; k++)
            read_id($sformatf("rand_id%0d", k), 8'($urandom_range(1, 255)),
                    8'($urandom), 8'($urandom), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
